// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: busy scoreboard for decode hazards plus a
// three-way round-robin writeback arbiter with a registered write port.
module regfile_write_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        reserve_valid,
    input  logic [4:0]  reserve_index,
    output logic        reserve_ready,
    input  logic [4:0]  read_a_index,
    input  logic [4:0]  read_b_index,
    output logic        read_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_index,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_index,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        link_valid,
    input  logic [4:0]  link_index,
    input  logic [31:0] link_data,
    output logic        link_ready,
    output logic        write_enable,
    output logic [4:0]  write_register,
    output logic [31:0] write_data
);

    logic [31:0] busy;
    logic [31:0] busy_next;
    logic [1:0]  pointer;
    logic [2:0]  req_valid;
    logic [2:0]  rot;
    logic [1:0]  offset;
    logic [2:0]  sum;
    logic        any_grant;
    logic [1:0]  winner;
    logic [2:0]  grant;
    logic [4:0]  win_index;
    logic [31:0] win_data;

    assign req_valid = {link_valid, mem_valid, alu_valid};

    // Outputs are forced low during reset so nothing is consumed mid-reset.
    assign reserve_ready = !reset && reserve_valid && !busy[reserve_index];
    assign read_stall    = !reset && (busy[read_a_index] || busy[read_b_index]);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rot       = req_valid;
        offset    = 2'd0;
        any_grant = 1'b0;
        win_index = 5'd0;
        win_data  = 32'd0;

        // Rotate so rot[0] is the requester named by the priority pointer.
        case (pointer)
            2'd1:    rot = {req_valid[0], req_valid[2], req_valid[1]};
            2'd2:    rot = {req_valid[1], req_valid[0], req_valid[2]};
            default: rot = req_valid;
        endcase

        if (rot[0]) begin
            offset    = 2'd0;
            any_grant = !reset;
        end else if (rot[1]) begin
            offset    = 2'd1;
            any_grant = !reset;
        end else if (rot[2]) begin
            offset    = 2'd2;
            any_grant = !reset;
        end

        sum    = {1'b0, pointer} + {1'b0, offset};
        winner = (sum >= 3'd3) ? pointer + offset + 2'd1 : pointer + offset;
        grant  = any_grant ? (3'b001 << winner) : 3'b000;

        case (winner)
            2'd1: begin
                win_index = mem_index;
                win_data  = mem_data;
            end
            2'd2: begin
                win_index = link_index;
                win_data  = link_data;
            end
            default: begin
                win_index = alu_index;
                win_data  = alu_data;
            end
        endcase
    end

    assign alu_ready  = grant[0];
    assign mem_ready  = grant[1];
    assign link_ready = grant[2];

    // Clear before set, so a same-edge set of a register being written wins.
    always_comb begin
        busy_next = busy;
        if (write_enable) begin
            busy_next[write_register] = 1'b0;
        end
        if (reserve_ready) begin
            busy_next[reserve_index] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy           <= 32'd0;
            pointer        <= 2'd0;
            write_enable   <= 1'b0;
            write_register <= 5'd0;
            write_data     <= 32'd0;
        end else begin
            busy <= busy_next;
            if (any_grant) begin
                pointer        <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
                write_enable   <= (win_index != 5'd0);
                write_register <= win_index;
                write_data     <= win_data;
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed vector table,
// hand-written reset/hazard sequences and randomized traffic against a model.
module tb_regfile_write_scheduler;

    localparam logic [31:0] ALU_D = 32'hDEADBEEF;
    localparam logic [31:0] MEM_D = 32'hCAFEF00D;
    localparam logic [31:0] LNK_D = 32'h00001234;

    logic        clk;
    logic        reset;
    logic        rv;
    logic [4:0]  ri;
    logic        reserve_ready;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        read_stall;
    logic        av, mv, lv;
    logic [4:0]  ai, mi, li;
    logic [31:0] ad, md, ld;
    logic        alu_ready, mem_ready, link_ready;
    logic        write_enable;
    logic [4:0]  write_register;
    logic [31:0] write_data;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_scheduler dut (
        .clk(clk), .reset(reset),
        .reserve_valid(rv), .reserve_index(ri), .reserve_ready(reserve_ready),
        .read_a_index(ra), .read_b_index(rb), .read_stall(read_stall),
        .alu_valid(av), .alu_index(ai), .alu_data(ad), .alu_ready(alu_ready),
        .mem_valid(mv), .mem_index(mi), .mem_data(md), .mem_ready(mem_ready),
        .link_valid(lv), .link_index(li), .link_data(ld), .link_ready(link_ready),
        .write_enable(write_enable), .write_register(write_register),
        .write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_busy[32];
    int          m_ptr;
    bit          m_we;
    int          m_wr;
    logic [31:0] m_wd;
    int          m_last_g;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ptr = 0;
        m_we  = 1'b0;
        m_wr  = 0;
        m_wd  = 32'd0;
    endtask

    function automatic int req_valid_of(int r);
        return (r == 0) ? int'(av) : (r == 1) ? int'(mv) : int'(lv);
    endfunction

    function automatic int req_idx(int r);
        return (r == 0) ? int'(ai) : (r == 1) ? int'(mi) : int'(li);
    endfunction

    function automatic logic [31:0] req_data(int r);
        return (r == 0) ? ad : (r == 1) ? md : ld;
    endfunction

    // Round-robin: first valid requester starting from the pointer.
    function automatic int model_pick();
        for (int k = 0; k < 3; k++) begin
            if (req_valid_of((m_ptr + k) % 3) != 0) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        bit acc;
        g   = model_pick();
        acc = rv && !m_busy[ri];
        if (m_we) m_busy[m_wr] = 1'b0;
        if (acc && ri != 0) m_busy[ri] = 1'b1;
        if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            m_wr  = req_idx(g);
            m_wd  = req_data(g);
            m_we  = (m_wr != 0);
        end else begin
            m_we = 1'b0;
        end
        m_last_g = g;
    endtask

    task automatic check_comb_model(input string tag);
        int g;
        g = model_pick();
        check({tag, "_rr"}, reserve_ready, rv && !m_busy[ri]);
        check({tag, "_stall"}, read_stall, m_busy[ra] || m_busy[rb]);
        check({tag, "_gnt"}, {link_ready, mem_ready, alu_ready},
              (g < 0) ? 3'b000 : (3'b001 << g));
    endtask

    task automatic check_regs_model(input string tag);
        check({tag, "_we"}, write_enable, m_we);
        check({tag, "_wr"}, write_register, m_wr);
        check({tag, "_wd"}, write_data, m_wd);
    endtask

    task automatic clear_inputs();
        rv = 0; ri = 0; ra = 0; rb = 0;
        av = 0; ai = 0; ad = ALU_D;
        mv = 0; mi = 0; md = MEM_D;
        lv = 0; li = 0; ld = LNK_D;
    endtask

    // Clock edge with the model advanced on the same edge; returns at edge+1.
    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rv;
        logic [4:0]  ri, ra, rb;
        logic        av;
        logic [4:0]  ai;
        logic        mv;
        logic [4:0]  mi;
        logic        lv;
        logic [4:0]  li;
        logic        rr, stall;
        logic [2:0]  gnt;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv_, logic [4:0] ri_, logic [4:0] ra_, logic [4:0] rb_,
                                logic av_, logic [4:0] ai_, logic mv_, logic [4:0] mi_,
                                logic lv_, logic [4:0] li_, logic rr_, logic st_,
                                logic [2:0] g_, logic we_, logic [4:0] wr_, logic [31:0] wd_);
        vec_t v;
        v.rv = rv_; v.ri = ri_; v.ra = ra_; v.rb = rb_;
        v.av = av_; v.ai = ai_; v.mv = mv_; v.mi = mi_; v.lv = lv_; v.li = li_;
        v.rr = rr_; v.stall = st_; v.gnt = g_; v.we = we_; v.wr = wr_; v.wd = wd_;
        return v;
    endfunction

    bit pv[3];
    int pi[3];
    logic [31:0] pd[3];

    initial begin
        //               rv ri ra rb av ai mv mi lv li  rr st gnt    we wr wd
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 0, 0, 32'd0));
        vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 0, 0, 32'd0));
        vecs.push_back(mk(0, 0, 5, 0, 1, 5, 0, 0, 0, 0,  0, 1, 3'b001, 1, 5, ALU_D));
        vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 0, 5, ALU_D));
        vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3'b000, 0, 5, ALU_D));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 3'b100, 0, 0, LNK_D));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 3,  0, 0, 3'b001, 1, 1, ALU_D));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 3,  0, 0, 3'b010, 1, 2, MEM_D));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 3,  0, 0, 3'b100, 1, 3, LNK_D));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 3,  0, 0, 3'b001, 1, 1, ALU_D));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0,  0, 0, 3'b010, 1, 4, MEM_D));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0,  0, 0, 3'b010, 1, 6, MEM_D));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 3,  0, 0, 3'b100, 1, 3, LNK_D));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 0, 3, LNK_D));
        vecs.push_back(mk(1, 9, 0, 9, 0, 0, 0, 0, 0, 0,  1, 0, 3'b000, 0, 3, LNK_D));
        vecs.push_back(mk(1, 9, 0, 9, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 0, 3, LNK_D));
        vecs.push_back(mk(0, 0, 0, 9, 1, 9, 0, 0, 0, 0,  0, 1, 3'b001, 1, 9, ALU_D));
        vecs.push_back(mk(0, 0, 0, 9, 0, 0, 0, 0, 0, 0,  0, 1, 3'b000, 0, 9, ALU_D));
        vecs.push_back(mk(0, 0, 0, 9, 0, 0, 0, 0, 0, 0,  0, 0, 3'b000, 0, 9, ALU_D));

        // Reset state, with every request input active.
        clear_inputs();
        rv = 1; ri = 4; av = 1; mv = 1; lv = 1; ai = 1; mi = 2; li = 3;
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_ready_async", {reserve_ready, link_ready, mem_ready, alu_ready}, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_ready", {reserve_ready, link_ready, mem_ready, alu_ready, read_stall}, 5'b0);
        check("rst_we", write_enable, 1'b0);
        check("rst_wr", write_register, 5'd0);
        check("rst_wd", write_data, 32'd0);
        clear_inputs();
        reset = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            rv = vecs[i].rv; ri = vecs[i].ri; ra = vecs[i].ra; rb = vecs[i].rb;
            av = vecs[i].av; ai = vecs[i].ai;
            mv = vecs[i].mv; mi = vecs[i].mi;
            lv = vecs[i].lv; li = vecs[i].li;
            #3;
            check($sformatf("v%0d_rr", i), reserve_ready, vecs[i].rr);
            check($sformatf("v%0d_stall", i), read_stall, vecs[i].stall);
            check($sformatf("v%0d_gnt", i), {link_ready, mem_ready, alu_ready}, vecs[i].gnt);
            edge_step();
            check($sformatf("v%0d_we", i), write_enable, vecs[i].we);
            check($sformatf("v%0d_wr", i), write_register, vecs[i].wr);
            check($sformatf("v%0d_wd", i), write_data, vecs[i].wd);
        end

        // Reset mid-cycle with a reservation and a writeback pending.
        do_reset();
        rv = 1; ri = 3;
        edge_step();
        rv = 0; ra = 3; mv = 1; mi = 3;
        #1;
        check("r27_stall_pre", read_stall, 1'b1);
        check("r27_ready_pre", mem_ready, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check("r27_ready_rst", mem_ready, 1'b0);
        check("r27_stall_rst", read_stall, 1'b0);
        mv = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("r27_we_rst", {write_enable, write_register}, 6'd0);
        #2;
        check("r27_stall_post", read_stall, 1'b0);
        edge_step();
        check("r27_no_write", write_enable, 1'b0);
        av = 1; ai = 1; mv = 1; mi = 2; lv = 1; li = 3;
        #2;
        check("r27_ptr0", {link_ready, mem_ready, alu_ready}, 3'b001);
        edge_step();
        check("r27_we_after", {write_enable, write_register}, {1'b1, 5'd1});

        // Reserve a register in the cycle its write is being retired.
        do_reset();
        rv = 1; ri = 7;
        edge_step();
        rv = 0; av = 1; ai = 7;
        #2;
        check("r26_alu_gnt", alu_ready, 1'b1);
        edge_step();
        av = 0; rv = 1; ri = 7; ra = 7;
        #2;
        check("r26_we", {write_enable, write_register}, {1'b1, 5'd7});
        check("r26_rr_blocked", reserve_ready, 1'b0);
        check("r26_stall_hold", read_stall, 1'b1);
        edge_step();
        #2;
        check("r26_rr_next", reserve_ready, 1'b1);
        edge_step();
        rv = 0;
        #2;
        check("r26_busy_again", read_stall, 1'b1);
        edge_step();

        // Randomized traffic against the model.
        do_reset();
        foreach (pv[r]) pv[r] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pv[r]) begin
                    pv[r] = ($urandom_range(0, 2) != 0);
                    pi[r] = $urandom_range(0, 7);
                    pd[r] = $urandom;
                end else if ($urandom_range(0, 9) == 0) begin
                    pv[r] = 1'b0;
                end
            end
            av = pv[0]; ai = 5'(pi[0]); ad = pd[0];
            mv = pv[1]; mi = 5'(pi[1]); md = pd[1];
            lv = pv[2]; li = 5'(pi[2]); ld = pd[2];
            rv = ($urandom_range(0, 1) != 0);
            ri = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            #3;
            check_comb_model($sformatf("rnd%0d", c));
            edge_step();
            check_regs_model($sformatf("rnd%0d", c));
            if (m_last_g >= 0) pv[m_last_g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
